// File: rtl/charge_mode_selector.sv
// rtl/charge_mode_selector.sv - PRECHARGE/CC/CV charge-mode FSM with dwell, hysteresis, OV latch-off (optional SLEW_LIMIT_EN)
module charge_mode_selector #(
    parameter int ADC_W      = 12,
    parameter int PWM_W      = 10,
    parameter int V_PRE      = 512,
    parameter int V_CV_ENTER = 1024,
    parameter int V_CV_EXIT  = 992,
    parameter int V_OV       = 1200,
    parameter int PRE_DUTY   = 64,
    parameter int DWELL      = 16,
    parameter int SLEW_STEP  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [ADC_W-1:0] V_battery,
    input  logic [PWM_W-1:0] PWM_counter_from_CC,
    input  logic [PWM_W-1:0] PWM_counter_from_CV,
    output logic [PWM_W-1:0] PWM_to_buck,
    output logic [2:0]       mode,
    output logic             flag_CC,
    output logic             fault
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRE   = 3'd1,
        S_CC    = 3'd2,
        S_CV    = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    localparam int CW = $clog2(DWELL) + 1;
    localparam logic [CW-1:0]    DWELL_LAST = CW'(DWELL - 1);
    localparam logic [ADC_W-1:0] TH_PRE     = ADC_W'(V_PRE);
    localparam logic [ADC_W-1:0] TH_ENTER   = ADC_W'(V_CV_ENTER);
    localparam logic [ADC_W-1:0] TH_EXIT    = ADC_W'(V_CV_EXIT);
    localparam logic [ADC_W-1:0] TH_OV      = ADC_W'(V_OV);
    localparam logic [PWM_W-1:0] DUTY_PRE   = PWM_W'(PRE_DUTY);

    state_t           state, next_state;
    logic [CW-1:0]    dwell_cnt, dwell_next;
    logic             cond, fire;
    logic [PWM_W-1:0] target, pwm_next;

    // Exit condition of the current state; the dwell counter qualifies it
    always_comb begin
        cond = 1'b0;
        case (state)
            S_PRE:   cond = (V_battery >= TH_PRE);
            S_CC:    cond = (V_battery >= TH_ENTER) || (V_battery < TH_PRE);
            S_CV:    cond = (V_battery < TH_EXIT);
            default: cond = 1'b0;
        endcase
        fire = cond && (dwell_cnt == DWELL_LAST);
    end

    // Next-state logic: disable beats overvoltage, which beats dwell-qualified moves
    always_comb begin
        next_state = state;
        if (!enable) begin
            next_state = S_IDLE;
        end else if ((state != S_FAULT) && (V_battery >= TH_OV)) begin
            next_state = S_FAULT;
        end else begin
            case (state)
                S_IDLE:  next_state = S_PRE;
                S_PRE:   if (fire) next_state = S_CC;
                S_CC: begin
                    if (fire && (V_battery >= TH_ENTER))
                        next_state = S_CV;
                    else if (fire)
                        next_state = S_PRE;
                end
                S_CV:    if (fire) next_state = S_CC;
                default: next_state = S_FAULT;
            endcase
        end
    end

    // Dwell counter restarts on any false sample and on every state change
    always_comb begin
        dwell_next = '0;
        if ((next_state == state) && cond)
            dwell_next = dwell_cnt + 1'b1;
    end

    // Compare value each state asks for
    always_comb begin
        target = '0;
        case (state)
            S_PRE:   target = DUTY_PRE;
            S_CC:    target = PWM_counter_from_CC;
            S_CV:    target = PWM_counter_from_CV;
            default: target = '0;
        endcase
    end

`ifdef SLEW_LIMIT_EN
    localparam logic [PWM_W-1:0] STEP =
        (SLEW_STEP >= (2 ** PWM_W)) ? {PWM_W{1'b1}} : PWM_W'(SLEW_STEP);
    logic [PWM_W-1:0] delta;

    // Walk toward the target by at most STEP; IDLE and FAULT drop to zero at once
    always_comb begin
        pwm_next = PWM_to_buck;
        delta    = '0;
        if ((state == S_IDLE) || (state == S_FAULT)) begin
            pwm_next = '0;
        end else if (target > PWM_to_buck) begin
            delta    = target - PWM_to_buck;
            pwm_next = PWM_to_buck + ((delta > STEP) ? STEP : delta);
        end else begin
            delta    = PWM_to_buck - target;
            pwm_next = PWM_to_buck - ((delta > STEP) ? STEP : delta);
        end
    end
`else
    // Compare value tracks the target directly, one cycle late
    always_comb begin
        pwm_next = target;
    end
`endif

    // State, dwell counter and compare-value registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            dwell_cnt   <= '0;
            PWM_to_buck <= '0;
        end else begin
            state       <= next_state;
            dwell_cnt   <= dwell_next;
            PWM_to_buck <= pwm_next;
        end
    end

    assign mode    = state;
    assign flag_CC = (state == S_CC);
    assign fault   = (state == S_FAULT);

endmodule
